// File: rtl/boot_pkg.sv
// Shared constants and FSM state encoding for the UART boot loader.
package boot_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam logic [7:0] ACK_BYTE  = 8'h06;
  localparam logic [7:0] NAK_BYTE  = 8'h15;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CSUM,
    RUN
  } boot_state_t;

  function automatic logic is_busy(boot_state_t s);
    return (s == LEN) || (s == DATA) || (s == CSUM);
  endfunction

endpackage

// File: rtl/boot_word_assembler.sv
// Collects bytes MSB-first into an INSTR_W word; word_done flags the byte completing a word.
module boot_word_assembler
  import boot_pkg::*;
#(
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [7:0]         byte_in,
  input  logic               byte_valid,
  output logic               word_done,
  output logic [INSTR_W-1:0] word
);

  localparam int BYTES = INSTR_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;

  logic [CNT_W-1:0] byte_cnt_reg;

  assign word_done = byte_valid && (byte_cnt_reg == CNT_W'(BYTES - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byte_cnt_reg <= '0;
    end else if (clr) begin
      byte_cnt_reg <= '0;
    end else if (byte_valid) begin
      byte_cnt_reg <= word_done ? '0 : byte_cnt_reg + 1'b1;
    end
  end

  // word exposes the completed word combinationally so the top can register it with the strobe
  generate
    if (BYTES > 1) begin : g_shift
      logic [INSTR_W-9:0] shift_reg;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          shift_reg <= '0;
        end else if (clr) begin
          shift_reg <= '0;
        end else if (byte_valid) begin
          shift_reg <= (INSTR_W-8)'({shift_reg, byte_in});
        end
      end

      assign word = {shift_reg, byte_in};
    end else begin : g_single
      assign word = byte_in;
    end
  endgenerate

endmodule

// File: rtl/uart_boot_loader.sv
// Framed UART program loader: SYNC, LEN, data words, CSUM; releases the CPU on a valid image.
// Optional BOOT_ACK_EN adds tx_data/tx_valid reporting ACK/NAK after each frame decision.
module uart_boot_loader
  import boot_pkg::*;
#(
  parameter int INSTR_W        = 16,
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  input  logic               reload,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_halt,
  output logic               load_busy,
  output logic               load_err,
`ifdef BOOT_ACK_EN
  output logic [7:0]         tx_data,
  output logic               tx_valid,
`endif
  output logic [ADDR_W-1:0]  words_loaded
);

  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  boot_state_t        state_reg;
  logic [7:0]         len_reg;
  logic [7:0]         word_cnt_reg;
  logic [7:0]         sum_reg;
  logic [TMO_W-1:0]   tmo_reg;

  logic               byte_take;
  logic               asm_clr;
  logic               asm_valid;
  logic               asm_done;
  logic [INSTR_W-1:0] asm_word;
  logic               tmo_hit;

  // reload outranks a coincident byte, which is simply dropped
  assign byte_take = rx_valid && !reload;
  assign asm_clr   = byte_take && (state_reg == IDLE) && (rx_data == SYNC_BYTE);
  assign asm_valid = byte_take && (state_reg == DATA);
  assign tmo_hit   = (tmo_reg == TMO_W'(TIMEOUT_CYCLES));

  boot_word_assembler #(
    .INSTR_W(INSTR_W)
  ) u_asm (
    .clk       (clk),
    .rst       (rst),
    .clr       (asm_clr),
    .byte_in   (rx_data),
    .byte_valid(asm_valid),
    .word_done (asm_done),
    .word      (asm_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      len_reg      <= '0;
      word_cnt_reg <= '0;
      sum_reg      <= '0;
      tmo_reg      <= '0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      cpu_halt     <= 1'b1;
      load_busy    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
`ifdef BOOT_ACK_EN
      tx_data      <= '0;
      tx_valid     <= 1'b0;
`endif
    end else begin
      imem_we <= asm_done;
      if (asm_done) begin
        imem_wdata <= asm_word;
      end
      if (imem_we) begin
        imem_addr <= imem_addr + 1'b1;
      end
`ifdef BOOT_ACK_EN
      tx_valid <= 1'b0;
`endif

      case (state_reg)
        IDLE: begin
          if (asm_clr) begin
            state_reg    <= LEN;
            load_busy    <= 1'b1;
            load_err     <= 1'b0;
            sum_reg      <= '0;
            imem_addr    <= '0;
            word_cnt_reg <= '0;
            tmo_reg      <= '0;
          end
        end

        RUN: begin
          if (reload) begin
            state_reg <= IDLE;
            cpu_halt  <= 1'b1;
          end
        end

        default: begin
          if (reload) begin
            state_reg <= IDLE;
            load_busy <= 1'b0;
            tmo_reg   <= '0;
          end else if (rx_valid) begin
            tmo_reg <= '0;
            case (state_reg)
              LEN: begin
                len_reg   <= rx_data;
                state_reg <= (rx_data == 8'd0) ? CSUM : DATA;
              end
              DATA: begin
                sum_reg <= sum_reg + rx_data;
                if (asm_done) begin
                  word_cnt_reg <= word_cnt_reg + 1'b1;
                  if (word_cnt_reg == len_reg - 8'd1) begin
                    state_reg <= CSUM;
                  end
                end
              end
              CSUM: begin
                load_busy <= 1'b0;
                if (rx_data == sum_reg) begin
                  state_reg    <= RUN;
                  cpu_halt     <= 1'b0;
                  words_loaded <= ADDR_W'(len_reg);
                end else begin
                  state_reg <= IDLE;
                  load_err  <= 1'b1;
                end
`ifdef BOOT_ACK_EN
                tx_valid <= 1'b1;
                tx_data  <= (rx_data == sum_reg) ? ACK_BYTE : NAK_BYTE;
`endif
              end
              default: ;
            endcase
          end else if (tmo_hit) begin
            state_reg <= IDLE;
            load_busy <= 1'b0;
            load_err  <= 1'b1;
            tmo_reg   <= '0;
`ifdef BOOT_ACK_EN
            tx_valid <= 1'b1;
            tx_data  <= NAK_BYTE;
`endif
          end else if (is_busy(state_reg)) begin
            tmo_reg <= tmo_reg + 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Randomized and directed frame bench for uart_boot_loader against a frame-level reference model.
module tb_uart_boot_loader;

  localparam int INSTR_W = 16;
  localparam int ADDR_W  = 8;
  localparam int TMO     = 50;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [7:0]         rx_data = 8'h00;
  logic               rx_valid = 1'b0;
  logic               reload = 1'b0;
  logic               imem_we;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_wdata;
  logic               cpu_halt;
  logic               load_busy;
  logic               load_err;
  logic [ADDR_W-1:0]  words_loaded;
`ifdef BOOT_ACK_EN
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic [7:0]         last_tx = 8'h00;
`endif

  uart_boot_loader #(
    .INSTR_W       (INSTR_W),
    .ADDR_W        (ADDR_W),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .reload      (reload),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_halt    (cpu_halt),
    .load_busy   (load_busy),
    .load_err    (load_err),
`ifdef BOOT_ACK_EN
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
`endif
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [23:0] wr_log[$];
  logic [23:0] exp_log[$];
  logic [7:0]  frame_q[$];
  int          exp_wl = 0;

  always @(negedge clk) begin
    if (rst && imem_we) wr_log.push_back({imem_addr, imem_wdata});
`ifdef BOOT_ACK_EN
    if (rst && tx_valid) last_tx = tx_data;
`endif
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  // last byte always goes with no trailing gap so the caller lands on the cycle after its strobe
  task automatic send_queue(input int gap_max);
    for (int i = 0; i < frame_q.size(); i++)
      send_byte(frame_q[i], (i == frame_q.size() - 1) ? 0 : $urandom_range(gap_max, 0));
  endtask

  task automatic pulse_reload();
    @(negedge clk);
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic check_outcome(input string tag, input bit good, input int n);
    check({tag, "_nwr"}, wr_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < wr_log.size(); i++)
      check({tag, "_wr"}, wr_log[i], exp_log[i]);
    if (good) exp_wl = n;
    check({tag, "_halt"}, cpu_halt, !good);
    check({tag, "_err"}, load_err, !good);
    check({tag, "_busy"}, load_busy, 1'b0);
    check({tag, "_wl"}, words_loaded, exp_wl);
`ifdef BOOT_ACK_EN
    check({tag, "_ack"}, last_tx, good ? 8'h06 : 8'h15);
`endif
    $display("frame %s n=%0d good=%0d writes=%0d", tag, n, good, wr_log.size());
  endtask

  // Reference model: build a frame from random words and predict its imem writes.
  task automatic build_frame(input int n, input bit bad);
    logic [15:0] w;
    logic [7:0]  sum;
    sum = 8'h00;
    frame_q.delete();
    exp_log.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = 16'($urandom);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      sum = 8'((int'(sum) + int'(w[15:8]) + int'(w[7:0])) % 256);
      exp_log.push_back({8'(i), w});
    end
    frame_q.push_back(bad ? sum + 8'd1 : sum);
  endtask

  task automatic load_directed(input logic [7:0] csum);
    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, csum};
    exp_log = '{{8'd0, 16'h1234}, {8'd1, 16'hABCD}};
    wr_log.delete();
  endtask

  initial begin
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_halt", cpu_halt, 1'b1);
    check("rst_we", imem_we, 1'b0);
    check("rst_busy", load_busy, 1'b0);
    check("rst_err", load_err, 1'b0);
    check("rst_wl", words_loaded, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Good frame
    load_directed(8'hBE);
    send_queue(0);
    check_outcome("good", 1'b1, 2);

    // Reload during RUN
    pulse_reload();
    check("reload_run_halt", cpu_halt, 1'b1);

    // Bad checksum, then the good frame again
    load_directed(8'hBF);
    send_queue(1);
    check_outcome("badcsum", 1'b0, 2);
    load_directed(8'hBE);
    send_queue(2);
    check_outcome("recover", 1'b1, 2);
    pulse_reload();

    // Timeout mid-DATA
    wr_log.delete();
    frame_q = '{8'hA5, 8'h01, 8'h12};
    send_queue(0);
    repeat (40) @(negedge clk);
    check("tmo_still_busy", load_busy, 1'b1);
    repeat (20) @(negedge clk);
    check("tmo_err", load_err, 1'b1);
    check("tmo_busy", load_busy, 1'b0);
    check("tmo_halt", cpu_halt, 1'b1);
    check("tmo_nwr", wr_log.size(), 0);
`ifdef BOOT_ACK_EN
    check("tmo_nak", last_tx, 8'h15);
`endif

    // Zero length with leading noise
    wr_log.delete();
    exp_log.delete();
    frame_q = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00};
    send_queue(1);
    check_outcome("zero", 1'b1, 0);
    pulse_reload();

    // Reload coinciding with a data byte mid-DATA
    wr_log.delete();
    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_queue(0);
    @(negedge clk);
    rx_data  = 8'hCD;
    rx_valid = 1'b1;
    reload   = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    reload   = 1'b0;
    check("rl_data_busy", load_busy, 1'b0);
    check("rl_data_err", load_err, 1'b0);
    check("rl_data_halt", cpu_halt, 1'b1);
    repeat (3) @(negedge clk);
    check("rl_data_nwr", wr_log.size(), 1);
    if (wr_log.size() > 0) check("rl_data_wr0", wr_log[0], {8'd0, 16'h1234});

    // Randomized frames with noise and inter-byte gaps
    for (int f = 0; f < 20; f++) begin
      int  n;
      bit  bad;
      logic [7:0] nz;
      n   = $urandom_range(6, 0);
      bad = ($urandom_range(3, 0) == 0);
      for (int k = $urandom_range(2, 0); k > 0; k--) begin
        nz = 8'($urandom);
        if (nz == 8'hA5) nz = 8'h5A;
        send_byte(nz, 0);
      end
      build_frame(n, bad);
      wr_log.delete();
      send_queue(3);
      check_outcome($sformatf("rand%0d", f), !bad, n);
      if (!bad) pulse_reload();
    end

    // Async reset mid-DATA after one word has been written
    load_directed(8'hBE);
    send_queue(0);
    check("pre_rst_run", cpu_halt, 1'b0);
    pulse_reload();
    frame_q = '{8'hA5, 8'h02, 8'h12, 8'h34};
    send_queue(0);
    repeat (2) @(negedge clk);
    check("pre_rst_addr", imem_addr, 1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_addr", imem_addr, 0);
    check("arst_wdata", imem_wdata, 0);
    check("arst_we", imem_we, 1'b0);
    check("arst_busy", load_busy, 1'b0);
    check("arst_halt", cpu_halt, 1'b1);
    check("arst_err", load_err, 1'b0);
    check("arst_wl", words_loaded, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_boot_loader.md
Name: uart_boot_loader

Overview:
- Sits between the UART receiver and the CPU instruction memory inside full_cpu.
- Parses a framed program image from decoded UART bytes and writes instruction words into imem.
- Holds the CPU halted until the image is loaded and its checksum verifies, then releases it.
- A reload pulse halts the CPU again and re-arms loading.

Parameters:
- INSTR_W, 16, instruction width in bits; must be a multiple of 8.
- ADDR_W, 8, imem address width.
- TIMEOUT_CYCLES, 1000000, maximum clk cycles allowed between bytes once a frame has started.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- rx_data  in  8  received byte
- rx_valid  in  1  one-cycle strobe, rx_data valid; no backpressure
- reload  in  1  one-cycle pulse: halt CPU, return to sync search
- imem_we  out  1  imem write strobe, one cycle per word
- imem_addr  out  ADDR_W  write address
- imem_wdata  out  INSTR_W  write data
- cpu_halt  out  1  1 = CPU held in reset/stall
- load_busy  out  1  frame in progress (states LEN, DATA, CSUM)
- load_err  out  1  sticky error flag
- words_loaded  out  ADDR_W  words written in the last frame

Behaviour:
- Frame format: SYNC 0xA5, LEN (word count N, 0..255), then N×(INSTR_W/8) data bytes with the most significant byte first, then CSUM.
- CSUM is the 8-bit sum, mod 256, of all data bytes. LEN and SYNC bytes are excluded from the sum.
- Reset values: state IDLE, cpu_halt=1, imem_we=0, imem_addr=0, imem_wdata=0, load_busy=0, load_err=0, words_loaded=0, sum=0, timeout counter=0.
- State IDLE:
  - rx_valid with 0xA5 → LEN; clears load_err, sum, and the address and byte counters.
  - Any other byte is ignored.
- State LEN:
  - On rx_valid, latch N.
  - N=0 → CSUM; otherwise → DATA.
- State DATA:
  - Shift each byte into the word register and add it to sum.
  - On the last byte of a word, assert imem_we for the next cycle only. imem_addr holds the word index, and imem_wdata holds the assembled word during the strobe.
  - After the strobe, the address increments.
  - After word N-1 is written → CSUM.
- State CSUM:
  - On rx_valid, compare the byte against sum.
  - Match → RUN. cpu_halt falls the cycle after the CSUM strobe, and words_loaded=N.
  - Mismatch → IDLE with load_err=1 and cpu_halt held at 1. Words already written stay in imem.
- State RUN:
  - cpu_halt=0.
  - rx_valid bytes are ignored.
  - reload → IDLE, and cpu_halt=1 the next cycle.
- Timeout:
  - In LEN, DATA and CSUM, the counter increments each cycle and clears on rx_valid.
  - When the counter reaches TIMEOUT_CYCLES → IDLE with load_err=1.
  - If rx_valid and timeout occur in the same cycle, rx_valid wins.
- reload during LEN, DATA or CSUM → IDLE with no error. A partially loaded program is never run.
- If reload and rx_valid occur in the same cycle, reload wins and the byte is dropped.
- In IDLE and CSUM, cpu_halt=1 always; it is 0 only in RUN.
- All counter widths wrap silently. The address cannot overflow because N ≤ 255 < 2^ADDR_W at the default width.

Optional Feature:
- Macro: BOOT_ACK_EN.
- Defined:
  - Adds output ports tx_data [7:0] and tx_valid.
  - One cycle after a CSUM decision, tx_valid pulses once. tx_data is 0x06 on match, 0x15 on mismatch or timeout.
  - If a reload coincides with the decision, no ack is sent.
- Undefined: the ports are absent, and no logic for them is generated.

Decomposition:
- Shared package boot_pkg holds:
  - constants SYNC_BYTE=8'hA5, ACK_BYTE=8'h06, NAK_BYTE=8'h15;
  - the state encoding (IDLE, LEN, DATA, CSUM, RUN).
- Sub-module boot_word_assembler:
  - takes a byte and strobe;
  - shifts bytes into an INSTR_W word;
  - outputs word_done and word;
  - has a synchronous clear input.
- The top level holds the FSM, checksum, timeout counter and address counter.

Test Plan:
- Good frame:
  - Stimulus: A5, 02, 12, 34, AB, CD, BE.
  - Response: imem writes addr0=16'h1234 and addr1=16'hABCD, one cycle each; cpu_halt falls one cycle after the BE strobe; words_loaded=2; load_err=0.
- Bad checksum:
  - Stimulus: same frame, but the last byte is BF.
  - Response: load_err=1, cpu_halt stays 1, state IDLE; under BOOT_ACK_EN, tx_data=0x15.
  - Follow-up: the good frame afterwards clears load_err and runs.
- Timeout:
  - Stimulus: A5, 01, 12, then silence for TIMEOUT_CYCLES (set to 50 in the bench).
  - Response: load_err=1, load_busy=0, no imem_we ever asserted.
- Zero length and noise:
  - Stimulus: bytes 00, FF, 5A, then A5, 00, 00.
  - Response: the noise bytes are ignored; no imem writes occur; cpu_halt falls; words_loaded=0.
- Reload:
  - During RUN: a reload pulse raises cpu_halt the next cycle.
  - Mid-DATA, with reload coinciding with rx_valid: the byte is dropped, the state returns to IDLE, load_err=0, cpu_halt=1.
- Async reset:
  - Stimulus: assert rst=0 mid-DATA, between clock edges.
  - Response: all outputs reach their reset values immediately.
